// File: rtl/pio_irq_ctrl_if.sv
// Signal bundle between the PIO state machines/host bus and the IRQ flag controller.
// The controller takes the slave modport; the master modport is the driving side.
interface pio_irq_ctrl_if #(
  parameter int NUM_SM    = 4,
  parameter int NUM_FLAGS = 8,
  parameter int NUM_LINES = 2
);
  localparam int FW = $clog2(NUM_FLAGS);

  logic [NUM_SM-1:0]    sm_irq_req;
  logic [2*NUM_SM-1:0]  sm_irq_op;
  logic [FW*NUM_SM-1:0] sm_irq_idx;
  logic [NUM_SM-1:0]    sm_irq_rel;
  logic [NUM_SM-1:0]    sm_wait_req;
  logic [NUM_SM-1:0]    sm_wait_pol;
  logic [FW*NUM_SM-1:0] sm_wait_idx;
  logic [NUM_SM-1:0]    sm_wait_rel;
  logic [NUM_SM-1:0]    sm_wait_ok;
  logic [NUM_SM-1:0]    sm_stall;
  logic                 host_we;
  logic [3:0]           host_addr;
  logic [31:0]          host_din;
  logic [31:0]          host_dout;
  logic [NUM_LINES-1:0] irq_out;

  modport master (
    output sm_irq_req, sm_irq_op, sm_irq_idx, sm_irq_rel,
    output sm_wait_req, sm_wait_pol, sm_wait_idx, sm_wait_rel,
    output host_we, host_addr, host_din,
    input  sm_wait_ok, sm_stall, host_dout, irq_out
  );

  modport slave (
    input  sm_irq_req, sm_irq_op, sm_irq_idx, sm_irq_rel,
    input  sm_wait_req, sm_wait_pol, sm_wait_idx, sm_wait_rel,
    input  host_we, host_addr, host_din,
    output sm_wait_ok, sm_stall, host_dout, irq_out
  );
endinterface

// File: rtl/pio_irq_ctrl.sv
// Shared PIO IRQ flag register: SM/host set-clear-consume arbitration (set wins),
// per-SM IRQ WAIT stall tracking, and per-line masked/forced system interrupts.
module pio_irq_ctrl #(
  parameter int NUM_SM    = 4,
  parameter int NUM_FLAGS = 8,
  parameter int NUM_SYS   = 4,
  parameter int NUM_LINES = 2
) (
  input  logic          clk,
  input  logic          rst,
  pio_irq_ctrl_if.slave bus
);
  localparam int FW = $clog2(NUM_FLAGS);
  localparam int SW = $clog2(NUM_SM);

  typedef enum logic {ST_IDLE, ST_WAIT} stall_e;

  stall_e               state_q [NUM_SM];
  stall_e               state_d [NUM_SM];
  logic [FW-1:0]        widx_q  [NUM_SM];
  logic [FW-1:0]        widx_d  [NUM_SM];
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_SYS-1:0]   inte_q  [NUM_LINES];
  logic [NUM_SYS-1:0]   inte_d  [NUM_LINES];
  logic [NUM_SYS-1:0]   intf_q  [NUM_LINES];
  logic [NUM_SYS-1:0]   intf_d  [NUM_LINES];
  logic [NUM_SYS-1:0]   ints    [NUM_LINES];
  logic [NUM_LINES-1:0] irq_q, irq_d;

  logic [FW-1:0]        irq_idx  [NUM_SM];
  logic [FW-1:0]        wait_idx [NUM_SM];
  logic [NUM_SM-1:0]    wait_ok;
  logic [NUM_FLAGS-1:0] set_v, clr_v;
  logic [31:0]          dout;

  // Relative mode rotates only the SM-select bits; the upper bits address a flag bank.
  function automatic logic [FW-1:0] resolve(input logic [FW-1:0] idx, input logic rel,
                                            input int sm);
    logic [FW-1:0] r;
    logic [SW-1:0] lo;
    r  = idx;
    lo = idx[SW-1:0] + SW'(sm);
    if (rel) r[SW-1:0] = lo;
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SM; i++) begin
      irq_idx[i]  = resolve(bus.sm_irq_idx[i*FW +: FW], bus.sm_irq_rel[i], i);
      wait_idx[i] = resolve(bus.sm_wait_idx[i*FW +: FW], bus.sm_wait_rel[i], i);
    end
  end

  // A consuming waiter loses to any lower-numbered consuming waiter on the same flag.
  always_comb begin
    wait_ok = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      wait_ok[i] = bus.sm_wait_req[i] & (flags_q[wait_idx[i]] == bus.sm_wait_pol[i]);
      for (int j = 0; j < i; j++) begin
        if (bus.sm_wait_pol[i] && bus.sm_wait_req[j] && bus.sm_wait_pol[j] &&
            (wait_idx[j] == wait_idx[i]))
          wait_ok[i] = 1'b0;
      end
    end
  end

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      state_d[i] = state_q[i];
      widx_d[i]  = widx_q[i];
      if (state_q[i] == ST_WAIT) begin
        if (!flags_q[widx_q[i]]) state_d[i] = ST_IDLE;
      end else if (bus.sm_irq_req[i]) begin
        case (bus.sm_irq_op[2*i +: 2])
          2'b00: set_v[irq_idx[i]] = 1'b1;
          2'b01: begin
            set_v[irq_idx[i]] = 1'b1;
            state_d[i]        = ST_WAIT;
            widx_d[i]         = irq_idx[i];
          end
          2'b10: clr_v[irq_idx[i]] = 1'b1;
          default: ;
        endcase
      end
      if (wait_ok[i] && bus.sm_wait_pol[i]) clr_v[wait_idx[i]] = 1'b1;
    end
    if (bus.host_we && bus.host_addr == 4'd0) clr_v = clr_v | bus.host_din[NUM_FLAGS-1:0];
    if (bus.host_we && bus.host_addr == 4'd1) set_v = set_v | bus.host_din[NUM_FLAGS-1:0];
    flags_d = set_v | (flags_q & ~clr_v);
  end

  always_comb begin
    dout = '0;
    case (bus.host_addr)
      4'd0:    dout = 32'(flags_q);
      4'd2:    dout = 32'(flags_q[NUM_SYS-1:0]);
      default: ;
    endcase
    for (int l = 0; l < NUM_LINES; l++) begin
      ints[l]   = (flags_q[NUM_SYS-1:0] | intf_q[l]) & inte_q[l];
      irq_d[l]  = |ints[l];
      inte_d[l] = inte_q[l];
      intf_d[l] = intf_q[l];
      if (bus.host_we && bus.host_addr == 4'(3 + 3*l)) inte_d[l] = bus.host_din[NUM_SYS-1:0];
      if (bus.host_we && bus.host_addr == 4'(4 + 3*l)) intf_d[l] = bus.host_din[NUM_SYS-1:0];
      if (bus.host_addr == 4'(3 + 3*l)) dout = 32'(inte_q[l]);
      if (bus.host_addr == 4'(4 + 3*l)) dout = 32'(intf_q[l]);
      if (bus.host_addr == 4'(5 + 3*l)) dout = 32'(ints[l]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      irq_q   <= '0;
      for (int i = 0; i < NUM_SM; i++) begin
        state_q[i] <= ST_IDLE;
        widx_q[i]  <= '0;
      end
      for (int l = 0; l < NUM_LINES; l++) begin
        inte_q[l] <= '0;
        intf_q[l] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      irq_q   <= irq_d;
      for (int i = 0; i < NUM_SM; i++) begin
        state_q[i] <= state_d[i];
        widx_q[i]  <= widx_d[i];
      end
      for (int l = 0; l < NUM_LINES; l++) begin
        inte_q[l] <= inte_d[l];
        intf_q[l] <= intf_d[l];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SM; i++) bus.sm_stall[i] = (state_q[i] == ST_WAIT);
  end

  assign bus.sm_wait_ok = wait_ok;
  assign bus.host_dout  = dout;
  assign bus.irq_out    = irq_q;

  if (NUM_FLAGS < 32) begin : g_din_hi
    logic unused_din_hi;
    assign unused_din_hi = ^bus.host_din[31:NUM_FLAGS];
  end
endmodule
